// File: rtl/mac_result_accumulator.sv
// mac_result_accumulator
// Issues operand pairs into a fixed-latency multiply-add stage, tracks each
// issue with a delayed {valid,last} tag, accumulates the returned results per
// dot-product group with saturation, and queues finished group sums in a
// 2-entry output FIFO. Issue is throttled so that every group in flight
// already owns a FIFO slot, so a completing group can never be dropped.
module mac_result_accumulator #(
    parameter int MAC_LATENCY = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_DEPTH   = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 ivalid,
    input  logic                 ilast,
    output logic                 oready,
    input  logic [31:0]          mac_result,
    output logic                 ovalid,
    input  logic                 iready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 sat
);

    // Sum is formed wide enough that neither operand can wrap before clamping.
    localparam int SW = ((ACC_WIDTH > 32) ? ACC_WIDTH : 32) + 2;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------
    logic       accept;
    logic [1:0] lif_reg, lif_next;
    logic [1:0] fc_reg, fc_next;
    logic [2:0] occupancy;

    // Slots already promised = groups in flight + groups waiting in the FIFO.
    assign occupancy = 3'(lif_reg) + 3'(fc_reg);
    assign oready    = (occupancy < 3'(OUT_DEPTH));
    assign accept    = ivalid && oready;

    // ------------------------------------------------------------------
    // Tag pipe: tag emerges in the same cycle as the matching mac_result
    // ------------------------------------------------------------------
    logic [MAC_LATENCY-1:0] tag_v_reg, tag_v_next;
    logic [MAC_LATENCY-1:0] tag_l_reg, tag_l_next;
    logic                   emerge_v;
    logic                   emerge_l;

    for (genvar gi = 0; gi < MAC_LATENCY; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_v_next[gi] = accept;
            assign tag_l_next[gi] = accept && ilast;
        end else begin : g_body
            assign tag_v_next[gi] = tag_v_reg[gi-1];
            assign tag_l_next[gi] = tag_l_reg[gi-1];
        end
    end

    assign emerge_v = tag_v_reg[MAC_LATENCY-1];
    assign emerge_l = tag_l_reg[MAC_LATENCY-1];

    // Shift the issue tags toward the accumulator
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_v_reg <= '0;
            tag_l_reg <= '0;
        end else begin
            tag_v_reg <= tag_v_next;
            tag_l_reg <= tag_l_next;
        end
    end

    // ------------------------------------------------------------------
    // Saturating accumulate
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic                        sticky_reg;
    logic signed [SW-1:0]        sum_wide;
    logic signed [ACC_WIDTH-1:0] sum_clamp;
    logic                        sat_now;
    logic                        push;
    logic                        push_sat;
    logic                        pop;

    assign sum_wide = SW'(acc_reg) + SW'($signed(mac_result));

    // Clamp the running sum to the signed accumulator range
    always_comb begin
        sum_clamp = sum_wide[ACC_WIDTH-1:0];
        sat_now   = 1'b0;
        if (sum_wide > SW'(ACC_MAX)) begin
            sum_clamp = ACC_MAX;
            sat_now   = 1'b1;
        end else if (sum_wide < SW'(ACC_MIN)) begin
            sum_clamp = ACC_MIN;
            sat_now   = 1'b1;
        end
    end

    assign push     = emerge_v && emerge_l;
    assign push_sat = sticky_reg || sat_now;

    // Fold valid results into the group sum; restart on the last one
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
        end else if (emerge_v) begin
            if (emerge_l) begin
                acc_reg    <= '0;
                sticky_reg <= 1'b0;
            end else begin
                acc_reg    <= sum_clamp;
                sticky_reg <= push_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    // Track groups whose last pair is issued but not yet summed
    always_comb begin
        lif_next = lif_reg;
        case ({accept && ilast, push})
            2'b10:   lif_next = lif_reg + 2'd1;
            2'b01:   lif_next = lif_reg - 2'd1;
            default: lif_next = lif_reg;
        endcase
    end

    // Track FIFO fill; push and pop together leave it unchanged
    always_comb begin
        fc_next = fc_reg;
        case ({push, pop})
            2'b10:   fc_next = fc_reg + 2'd1;
            2'b01:   fc_next = fc_reg - 2'd1;
            default: fc_next = fc_reg;
        endcase
    end

    // Register both occupancy counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lif_reg <= '0;
            fc_reg  <= '0;
        end else begin
            lif_reg <= lif_next;
            fc_reg  <= fc_next;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (two entries, ping-pong pointers)
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] mem_data_reg [2];
    logic                        mem_sat_reg  [2];
    logic                        wr_ptr_reg;
    logic                        rd_ptr_reg;

    assign ovalid = (fc_reg != 2'd0);
    assign pop    = ovalid && iready;
    assign result = ovalid ? mem_data_reg[rd_ptr_reg] : '0;
    assign sat    = ovalid ? mem_sat_reg[rd_ptr_reg] : 1'b0;

    // Write completed group sums and advance the read side on pop
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data_reg[i] <= '0;
                mem_sat_reg[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data_reg[wr_ptr_reg] <= sum_clamp;
                mem_sat_reg[wr_ptr_reg]  <= push_sat;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed bench for mac_result_accumulator. The bench plays the multiply-add
// stage itself: each accepted pair's value is returned on mac_result exactly
// MAC_LATENCY cycles later (random junk otherwise). A group-level model
// predicts FIFO contents, ovalid timing and oready every cycle; a pop log is
// afterwards pinned against hand-computed sums.
module tb_mac_result_accumulator;

    localparam int L  = 3;
    localparam int AW = 18;
    localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN = -AMAX - 1;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          ivalid = 1'b0;
    logic          ilast = 1'b0;
    logic          oready;
    logic [31:0]   mac_result = '0;
    logic          ovalid;
    logic          iready = 1'b0;
    logic [AW-1:0] result;
    logic          sat;

    mac_result_accumulator #(
        .MAC_LATENCY(L),
        .ACC_WIDTH  (AW),
        .OUT_DEPTH  (2)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ivalid    (ivalid),
        .ilast     (ilast),
        .oready    (oready),
        .mac_result(mac_result),
        .ovalid    (ovalid),
        .iready    (iready),
        .result    (result),
        .sat       (sat)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        longint sum;
        bit     s;
        int     rdy;
    } grp_t;

    grp_t   fq[$];
    longint m_acc = 0;
    bit     m_sticky = 1'b0;
    int     sched_val[16];
    bit     sched_v[16];
    int     cur_val = 0;
    bit     last_acc = 1'b0;
    int     errors = 0;
    int     checks = 0;
    longint pop_res[$];
    bit     pop_sat[$];
    int     rise_cyc[$];
    bit     prev_ov = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Model + compare, once per cycle at the falling edge
    initial begin
        forever begin
            bit     e_ov;
            bit     e_ordy;
            longint e_res;
            bit     e_sat;
            bit     sn;
            longint s;
            int     slot;
            @(negedge clock);
            slot = cyc % 16;
            mac_result = sched_v[slot] ? sched_val[slot] : $urandom;
            sched_v[slot] = 1'b0;
            if (!resetn) begin
                fq.delete();
                m_acc = 0;
                m_sticky = 1'b0;
                for (int i = 0; i < 16; i++) sched_v[i] = 1'b0;
                chk("rst_ovalid", longint'(ovalid), 0);
                chk("rst_result", longint'($signed(result)), 0);
                chk("rst_sat", longint'(sat), 0);
                last_acc = 1'b0;
                prev_ov = 1'b0;
            end else begin
                e_ov   = (fq.size() > 0) && (fq[0].rdy <= cyc);
                e_res  = e_ov ? fq[0].sum : 0;
                e_sat  = e_ov ? fq[0].s : 1'b0;
                e_ordy = (fq.size() < 2);
                chk("ovalid", longint'(ovalid), longint'(e_ov));
                chk("result", longint'($signed(result)), e_res);
                chk("sat", longint'(sat), longint'(e_sat));
                chk("oready", longint'(oready), longint'(e_ordy));
                if (ovalid && !prev_ov) rise_cyc.push_back(cyc);
                prev_ov = ovalid;
                if (ovalid && iready) begin
                    pop_res.push_back(longint'($signed(result)));
                    pop_sat.push_back(sat);
                end
                last_acc = ivalid && e_ordy;
                if (last_acc) begin
                    sched_val[(cyc + L) % 16] = cur_val;
                    sched_v[(cyc + L) % 16]   = 1'b1;
                    s  = m_acc + longint'(cur_val);
                    sn = 1'b0;
                    if (s > AMAX) begin s = AMAX; sn = 1'b1; end
                    if (s < AMIN) begin s = AMIN; sn = 1'b1; end
                    if (ilast) begin
                        fq.push_back('{sum: s, s: m_sticky | sn, rdy: cyc + L + 1});
                        m_acc = 0;
                        m_sticky = 1'b0;
                    end else begin
                        m_acc = s;
                        m_sticky = m_sticky | sn;
                    end
                end
                if (e_ov && iready) void'(fq.pop_front());
            end
        end
    end

    // Present one pair and hold it until accepted; called at posedge+1
    task automatic send(input bit l, input int val);
        int n = 0;
        ivalid  = 1'b1;
        ilast   = l;
        cur_val = val;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) chk("send_timeout", 0, 1);
        $display("issue cyc=%0d last=%0d val=%0d", cyc - 1, l, val);
        ivalid = 1'b0;
        ilast  = 1'b0;
    endtask

    task automatic send_group(input int n, input int val);
        for (int i = 1; i <= n; i++) send(i == n, val);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    longint exp_res[17] = '{114, -32768, 10, 131071, 1, -131072, -131072,
                            11, 12, 13, 3, 6, 9, 12, 15, 18, 8};
    bit     exp_sat[17] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int cl;
        resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        iready = 1'b1;
        idle(2);

        // Basic group
        send(0, 10); send(0, -3); send(0, 7); send(1, 100);
        cl = cyc - 1;
        idle(8);

        // Single-pair group followed immediately by a 2-pair group
        send(1, -32768); send(0, 5); send(1, 5);
        idle(8);

        // Saturation and sticky clear, plus exact-minimum boundary
        send_group(3, 65025);
        send_group(1, 1);
        send_group(4, -32768);
        send_group(5, -32768);
        idle(8);

        // Back-pressure: third single group held until a pop frees a slot
        iready = 1'b0;
        send(1, 11);
        send(1, 12);
        @(negedge clock);
        chk("oready_full", longint'(oready), 0);
        @(posedge clock);
        #1;
        fork
            send(1, 13);
            begin
                idle(6);
                iready = 1'b1;
                idle(1);
                iready = 1'b0;
            end
        join
        iready = 1'b1;
        idle(10);

        // iready toggling with continuous 2-pair groups
        fork
            for (int k = 1; k <= 6; k++) begin
                send(0, k);
                send(1, 2 * k);
            end
            repeat (40) begin
                @(posedge clock);
                #1;
                iready = ~iready;
            end
        join
        iready = 1'b1;
        idle(10);

        // Reset mid-group with a queued sum and two tags in flight
        iready = 1'b0;
        send(1, 7);
        idle(2);
        send(0, 50);
        send(0, 60);
        resetn = 1'b0;
        @(negedge clock);
        chk("reset_ovalid_now", longint'(ovalid), 0);
        @(posedge clock);
        #1;
        idle(2);
        resetn = 1'b1;
        iready = 1'b1;
        send(0, 4); send(1, 4);
        idle(8);

        // Hand-computed expectations
        chk("first_latency", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, cl + 4);
        chk("pop_count", pop_res.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < pop_res.size()) begin
                $display("pop %0d result=%0d sat=%0d", i, pop_res[i], pop_sat[i]);
                chk($sformatf("pop%0d_result", i), pop_res[i], exp_res[i]);
                chk($sformatf("pop%0d_sat", i), longint'(pop_sat[i]), longint'(exp_sat[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
